// File: rtl/quiz_buzzer_arbiter.sv
// N-team buzzer arbiter: debounced first-press lock-out, timed winner LED, saturating score edit.
// Optional macro BUZZ_REARM_EN: a team must release its buzzer in IDLE before it can win again.
`timescale 1ns/1ps
module quiz_buzzer_arbiter #(
  parameter int N_TEAMS      = 4,
  parameter int SCORE_W      = 4,
  parameter int DEBOUNCE_CYC = 50_000_000,
  parameter int HOLD_CYC     = 300_000_000,
  parameter int REPEAT_CYC   = 25_000_000,
  parameter int CNT_W        = 32,
  localparam int ID_W        = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TEAMS-1:0]         buzz,
  input  logic                       score_on,
  input  logic [N_TEAMS-1:0]         team_sel,
  input  logic                       inc,
  input  logic                       dec,
  output logic [N_TEAMS-1:0]         led,
  output logic                       winner_valid,
  output logic [ID_W-1:0]            winner_id,
  output logic [1:0]                 state,
  output logic [N_TEAMS*SCORE_W-1:0] scores
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_SCORE  = 2'd2,
    S_BAD    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e                     state_q, state_d;
  logic [N_TEAMS-1:0]         led_q, led_d;
  logic                       vld_q, vld_d;
  logic [ID_W-1:0]            wid_q, wid_d;
  logic [N_TEAMS*SCORE_W-1:0] scores_q, scores_d;
  logic [CNT_W-1:0]           cnt_q [N_TEAMS];
  logic [CNT_W-1:0]           cnt_d [N_TEAMS];
  logic [CNT_W-1:0]           hold_q, hold_d, rep_q, rep_d, rep_eff;
  logic [N_TEAMS-1:0]         sel_prev_q;
  logic                       inc_prev_q, dec_prev_q;
  logic [N_TEAMS-1:0]         qual, win_oh, armed;
  logic [ID_W-1:0]            win_idx;
  logic                       edit, edit_chg;

`ifdef BUZZ_REARM_EN
  logic [N_TEAMS-1:0]         armed_q, armed_d;
  assign armed = armed_q;
`else
  assign armed = '1;
`endif

  function automatic logic [SCORE_W-1:0] sat_step(input logic [SCORE_W-1:0] v, input logic up);
    if (up) return (&v) ? v : v + SCORE_W'(1);
    else    return (v == '0) ? v : v - SCORE_W'(1);
  endfunction

  // A change of selection or direction restarts the repeat interval, counting the current cycle.
  assign edit     = $onehot(team_sel) && (inc ^ dec);
  assign edit_chg = (team_sel != sel_prev_q) || (inc != inc_prev_q) || (dec != dec_prev_q);
  assign rep_eff  = edit_chg ? '0 : rep_q;

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    vld_d    = vld_q;
    wid_d    = wid_q;
    scores_d = scores_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    qual     = '0;
    win_oh   = '0;
    win_idx  = '0;
`ifdef BUZZ_REARM_EN
    armed_d  = armed_q;
`endif
    case (state_q)
      S_IDLE: begin
        rep_d = '0;
        if (score_on) begin
          state_d = S_SCORE;
          for (int i = 0; i < N_TEAMS; i++) cnt_d[i] = '0;
        end else begin
          for (int i = 0; i < N_TEAMS; i++) begin
            qual[i] = buzz[i] && armed[i] && (cnt_q[i] == DEB_MAX);
`ifdef BUZZ_REARM_EN
            if (!buzz[i]) armed_d[i] = 1'b1;
`endif
          end
          // Scan high to low so the lowest qualifying index is the one kept.
          for (int i = N_TEAMS - 1; i >= 0; i--) begin
            if (qual[i]) begin
              win_oh    = '0;
              win_oh[i] = 1'b1;
              win_idx   = ID_W'(i);
            end
          end
          if (|qual) begin
            state_d = S_LOCKED;
            led_d   = win_oh;
            vld_d   = 1'b1;
            wid_d   = win_idx;
            hold_d  = '0;
            for (int i = 0; i < N_TEAMS; i++) cnt_d[i] = '0;
`ifdef BUZZ_REARM_EN
            armed_d = '0;
`endif
          end else begin
            for (int i = 0; i < N_TEAMS; i++) begin
              if (!buzz[i])                               cnt_d[i] = '0;
              else if (armed[i] && (cnt_q[i] < DEB_MAX))  cnt_d[i] = cnt_q[i] + ONE;
            end
          end
        end
      end
      S_LOCKED: begin
        if (hold_q == HOLD_MAX) begin
          state_d = S_IDLE;
          led_d   = '0;
          vld_d   = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + ONE;
        end
      end
      S_SCORE: begin
        if (!score_on) begin
          state_d = S_IDLE;
          rep_d   = '0;
        end else if (edit) begin
          if (rep_eff == REP_MAX) begin
            rep_d = '0;
            for (int i = 0; i < N_TEAMS; i++)
              if (team_sel[i]) scores_d[i*SCORE_W +: SCORE_W] = sat_step(scores_q[i*SCORE_W +: SCORE_W], inc);
          end else begin
            rep_d = rep_eff + ONE;
          end
        end else begin
          rep_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = '0;
        vld_d   = 1'b0;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      vld_q      <= 1'b0;
      wid_q      <= '0;
      scores_q   <= '0;
      hold_q     <= '0;
      rep_q      <= '0;
      sel_prev_q <= '0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      for (int i = 0; i < N_TEAMS; i++) cnt_q[i] <= '0;
`ifdef BUZZ_REARM_EN
      armed_q    <= '1;
`endif
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      vld_q      <= vld_d;
      wid_q      <= wid_d;
      scores_q   <= scores_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      sel_prev_q <= team_sel;
      inc_prev_q <= inc;
      dec_prev_q <= dec;
      cnt_q      <= cnt_d;
`ifdef BUZZ_REARM_EN
      armed_q    <= armed_d;
`endif
    end
  end

  assign led          = led_q;
  assign winner_valid = vld_q;
  assign winner_id    = wid_q;
  assign state        = state_q;
  assign scores       = scores_q;

endmodule

// File: doc/quiz_buzzer_arbiter.md
Name: quiz_buzzer_arbiter

Overview:
Parametrised N-team buzzer arbiter with priority detection, timed winner indication and per-team score registers with auto-repeat increment/decrement. Successor to the fixed three-team buzzer controller. Generalised in team count, score width and all timing constants; adds saturating scores, deterministic tie-break and a winner index output. Drives the LED bank and the score display path; the display decoder consumes `scores` and `state`.

Parameters:
N_TEAMS, 4, number of teams/buzzers (2..8)
SCORE_W, 4, width of each team score
DEBOUNCE_CYC, 50_000_000, consecutive cycles a buzzer must be held to qualify
HOLD_CYC, 300_000_000, cycles the winner LED stays lit
REPEAT_CYC, 25_000_000, cycles per score step while inc/dec is held
CNT_W, 32, width of every timing counter (must hold max of the above)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
buzz  in  N_TEAMS  buzzer inputs, bit i = team i, level-sensitive
score_on  in  1  score-edit mode request
team_sel  in  N_TEAMS  one-hot team select for score edit
inc  in  1  increment request (held)
dec  in  1  decrement request (held)
led  out  N_TEAMS  one-hot winner indicator
winner_valid  out  1  high while led is non-zero
winner_id  out  max(1,$clog2(N_TEAMS))  index of most recent winner
state  out  2  0=IDLE, 1=LOCKED, 2=SCORE
scores  out  N_TEAMS*SCORE_W  team i score at bits [i*SCORE_W +: SCORE_W]

Behaviour:
- Reset (`rst` sampled high on a `clk` edge) sets: state IDLE; led 0; winner_valid 0; winner_id 0; all scores 0; all counters 0. Reset mid-LOCKED or mid-SCORE aborts immediately.
- IDLE, score_on=1: go to SCORE next edge. Debounce counters are cleared and buzz is ignored that cycle.
- IDLE, score_on=0: per-team counter cnt[i].
  - buzz[i]=1 and cnt[i]<DEBOUNCE_CYC-1: increment cnt[i].
  - buzz[i]=0: clear cnt[i].
  - Team i qualifies on the edge where buzz[i]=1 and cnt[i]==DEBOUNCE_CYC-1. A buzzer held from the first edge therefore wins on its DEBOUNCE_CYC-th edge.
- Win: on a qualifying edge, state becomes LOCKED, led becomes one-hot bit w, winner_id becomes w, and all cnt are cleared. If several teams qualify on the same edge, the lowest index wins.
- LOCKED:
  - led held for exactly HOLD_CYC cycles via the hold counter.
  - On the edge where the hold counter reaches HOLD_CYC-1: led becomes 0, hold counter clears, state returns to IDLE.
  - buzz, score_on, inc and dec are ignored; cnt stays 0.
  - winner_id keeps its value until the next win.
- SCORE:
  - score_on=0: return to IDLE next edge and clear the repeat counter.
  - Edit is active only if team_sel has exactly one bit set and exactly one of inc/dec is high. Otherwise the repeat counter is cleared and scores are unchanged.
  - While edit is active, the repeat counter increments. On the edge where it equals REPEAT_CYC-1, the selected score steps by ±1 and the counter clears. Auto-repeat therefore runs every REPEAT_CYC cycles while held.
  - Any change of team_sel or of inc/dec between consecutive cycles clears the repeat counter.
  - Saturating arithmetic: increment at 2^SCORE_W-1 holds the value; decrement at 0 holds 0. No wrap.
- The state encoding 3 is unreachable. If it is ever entered, return to IDLE next edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
BUZZ_REARM_EN
- Defined: each team has an armed flag, cleared on every win and set once buzz[i] is sampled low in IDLE. cnt[i] may only increment while team i is armed, so a buzzer still held when LOCKED ends cannot re-win without being released first. Reset sets all flags armed.
- Undefined: no armed flags. A buzzer held across LOCKED→IDLE starts counting on the first IDLE edge.

Test Plan:
All scenarios use N_TEAMS=4, SCORE_W=4, DEBOUNCE_CYC=4, HOLD_CYC=8, REPEAT_CYC=3.
- buzz=4'b0100 held from reset release -> after 4th edge state=1, led=4'b0100, winner_id=2, winner_valid=1; exactly 8 cycles later led=0 and state=0.
- buzz=4'b1010 rising on the same cycle and held -> winner_id=1, led=4'b0010; bit 3 is never lit.
- buzz[0] high for 3 cycles, low 1 cycle, then high 4 cycles -> no win until the 4th cycle of the second pulse, i.e. the debounce counter restarts.
- score_on=1, team_sel=4'b0001, inc held 9 cycles -> score0=3; then dec held 15 cycles -> score0=0, saturates at 0 with no wrap.
- score0 preset to 14 via inc, inc held 9 more cycles -> score0=15 and holds; inc+dec together or team_sel=4'b0011 -> no change.
- rst asserted mid-LOCKED -> next edge state=0, led=0, scores=0.
- BUZZ_REARM_EN: buzz[1] held through LOCKED -> no second win until buzz[1] is released for ≥1 cycle.
- BUZZ_REARM_EN undefined: buzz[1] held through LOCKED -> team 1 re-wins 4 edges after LOCKED ends.
